alu_result_fifo: RTL
====================

Name: alu_result_fifo

Overview:
- Downstream stage of the arithmetic logic unit.
- Captures each result/status pair the ALU produces, using a valid/ready handshake, into a small circular FIFO.
- Presents pairs in order to the consumer (register-file writeback or host readout).
- Keeps sticky status flags and a saturating count of accepted operations for debug and interrupt logic.

Parameters:
- RES_W, 9, width of ALU result word (matches ALU o_result width N+1 with N=8).
- STAT_W, 4, width of ALU status word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the accepted-operation counter.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  ALU result/status valid this cycle.
- i_result  input  RES_W  ALU result.
- i_status  input  STAT_W  ALU status flags.
- o_ready  output  1  FIFO can accept (not full).
- o_valid  output  1  head entry available (not empty).
- o_result  output  RES_W  head entry result.
- o_status  output  STAT_W  head entry status.
- i_ready  input  1  consumer pops head when o_valid and i_ready.
- i_clear  input  1  synchronous clear of sticky flags and counter.
- o_sticky  output  STAT_W  OR of status of all accepted entries since last clear/reset.
- o_count  output  CNT_W  accepted-entry count, saturating.
- o_full  output  1  occupancy == DEPTH.
- o_empty  output  1  occupancy == 0.

Behaviour:
- Reset (i_reset low, asynchronous assert, synchronous-to-clock release):
  - read and write pointers, occupancy, o_sticky and o_count all 0.
  - o_valid=0, o_empty=1, o_full=0, o_ready=1.
  - o_result and o_status read 0 while empty.
  - Storage array is not reset.
- Reset mid-operation discards all entries; no partial pop is visible.
- Push: i_valid && o_ready at the clock edge.
  - Writes {i_result,i_status} at the write pointer; write pointer increments modulo DEPTH.
- Pop: o_valid && i_ready at the clock edge; read pointer increments modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Occupancy is a separate counter of width log2(DEPTH)+1:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop.
- o_ready = !o_full, combinational from registered occupancy. No bypass:
  - when full, a same-cycle pop does not enable a push;
  - when empty, a same-cycle push is not poppable.
- Push while full is ignored; the producer must hold i_valid.
- Pop while empty is ignored.
- Latency: an entry pushed at edge k is visible on o_valid/o_result/o_status after edge k (first-word fall-through from storage, one-cycle latency).
- o_result and o_status are driven combinationally from storage at the read pointer, gated to 0 when empty.
- Sticky flags: o_sticky <= o_sticky | i_status on each push.
- Count: o_count increments on each push and saturates at all-ones (no wrap).
- i_clear:
  - o_sticky <= 0 and o_count <= 0.
  - If a push occurs in the same cycle, clear wins for the previous contents and the new entry still contributes: o_sticky <= i_status, o_count <= 1.
  - i_clear does not affect FIFO contents.
- Ordering is strict FIFO; no entry is dropped or duplicated.

Decomposition:
- Shared package alu_pkg holds:
  - RES_W and STAT_W defaults.
  - Status bit index constants: STAT_LT=0 (A<B), STAT_BIT=1 (bit-test zero), 2 and 3 reserved.
  - typedef alu_entry_t as a packed struct {result, status}.
- One natural sub-module, alu_fifo_mem: DEPTH x alu_entry_t storage with one synchronous write port and one asynchronous read port.
- Pointer, occupancy, sticky and counter logic stays in the top module.

Test Plan:
- Reset: drive i_reset low mid-traffic after 3 pushes -> o_valid=0, o_empty=1, o_count=0, o_sticky=0 immediately (asynchronous), o_ready=1.
- Fill and drain:
  - push results 9'h001, 9'h002, 9'h003, 9'h004 with i_ready=0 -> o_full=1 and o_ready=0 after the 4th edge; a 5th push of 9'h1FF is ignored.
  - Then hold i_ready=1 -> outputs 001, 002, 003, 004 in order, then o_empty=1.
- Wrap and simultaneous:
  - with occupancy 2 (pointers near wrap), push and pop every cycle for 10 cycles with incrementing results -> occupancy stays 2 and output sequence is in order with no gaps.
- Full plus pop with push attempt: when full, assert i_valid and i_ready together -> only the pop occurs; occupancy becomes 3; the pushed value is accepted on the next cycle.
- Sticky and clear:
  - push status 4'b0001 then 4'b0010 -> o_sticky=4'b0011, o_count=2.
  - Then i_clear with a push of status 4'b0100 -> o_sticky=4'b0100, o_count=1.
- Counter saturation: with CNT_W=4, push 20 entries while popping -> o_count holds at 15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU types and constants: default widths, status bit positions and the
// result/status entry carried from the ALU to its consumers.
package alu_pkg;

  localparam int unsigned RES_W  = 9;
  localparam int unsigned STAT_W = 4;

  localparam int unsigned STAT_LT  = 0;  // A < B
  localparam int unsigned STAT_BIT = 1;  // bit-test result was zero

  typedef struct packed {
    logic [RES_W-1:0]  result;
    logic [STAT_W-1:0] status;
  } alu_entry_t;

endpackage

// File: rtl/alu_fifo_mem.sv
// DEPTH-entry storage with one synchronous write port and one asynchronous read port.
// Contents are intentionally not reset.
module alu_fifo_mem
  import alu_pkg::*;
#(
  parameter type         T     = alu_entry_t,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  T              i_wdata,
  input  logic [AW-1:0] i_raddr,
  output T              o_rdata
);

  T mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) mem_q[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/alu_result_fifo.sv
// Captures ALU result/status pairs into a small circular FIFO and tracks sticky
// status flags plus a saturating count of accepted operations.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter int unsigned RES_W  = alu_pkg::RES_W,
  parameter int unsigned STAT_W = alu_pkg::STAT_W,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [RES_W-1:0]  i_result,
  input  logic [STAT_W-1:0] i_status,
  output logic              o_ready,
  output logic              o_valid,
  output logic [RES_W-1:0]  o_result,
  output logic [STAT_W-1:0] o_status,
  input  logic              i_ready,
  input  logic              i_clear,
  output logic [STAT_W-1:0] o_sticky,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    logic [RES_W-1:0]  result;
    logic [STAT_W-1:0] status;
  } entry_t;

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       occ_q, occ_d;
  logic [STAT_W-1:0] sticky_q, sticky_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  entry_t            wr_entry, rd_entry;

  // Full/empty come from registered occupancy only, so there is no bypass path.
  assign o_full  = (occ_q == (AW+1)'(DEPTH));
  assign o_empty = (occ_q == '0);
  assign o_ready = !o_full;
  assign o_valid = !o_empty;

  assign push = i_valid && !o_full;
  assign pop  = i_ready && !o_empty;

  assign wr_entry.result = i_result;
  assign wr_entry.status = i_status;

  alu_fifo_mem #(
    .T     (entry_t),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push),
    .i_waddr (wr_ptr_q),
    .i_wdata (wr_entry),
    .i_raddr (rd_ptr_q),
    .o_rdata (rd_entry)
  );

  assign o_result = o_empty ? '0 : rd_entry.result;
  assign o_status = o_empty ? '0 : rd_entry.status;
  assign o_sticky = sticky_q;
  assign o_count  = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (pop && !push) occ_d = occ_q - 1'b1;
  end

  // Clear discards the previous totals; a same-cycle push still counts.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (i_clear) begin
      sticky_d = push ? i_status : '0;
      count_d  = push ? CNT_W'(1) : '0;
    end else if (push) begin
      sticky_d = sticky_q | i_status;
      count_d  = (count_q == '1) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

endmodule
